// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states,
// opcodes, ALU operation classes, ALU controls and immediate formats.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } statetype_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Unsupported opcodes fall back to the I format so the extender stays quiet.
  function automatic logic [1:0] immSrcFor(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decoder: maps the controller's ALU operation
// class plus instruction fields onto the ALU function select.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op5,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_control
);

  // op[5] separates R-type from I-type, so addi never turns into a subtract.
  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I controller FSM sequencing a shared ALU, register file and
// a single memory port that completes on a mem_ready handshake.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       illegal_op
);

  statetype_t r_state;
  statetype_t w_next;
  logic [1:0] w_alu_op;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  // Outputs are Moore-style except the handshake strobes, which react to
  // mem_ready and zero in the same cycle.
  always_comb begin
    w_next     = r_state;
    w_alu_op   = ALUOP_ADD;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    illegal_op = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        w_alu_op  = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_alu_op  = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        w_alu_op  = ALUOP_SUB;
        pc_write  = zero;
        w_next    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        w_next    = S_ALUWB;
      end
      S_TRAP: begin
        illegal_op = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign imm_src = immSrcFor(op);

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_op5         (op[5]),
    .i_funct7b5    (funct7b5),
    .o_alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instruction table,
// randomized instruction stream, and hand-written reset/trap sequences.
module tb_multicycle_controller;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  typedef struct packed {
    logic       memReq;
    logic       memWrite;
    logic       adrSrc;
    logic       irWrite;
    logic       pcWrite;
    logic       regWrite;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resultSrc;
    logic [2:0] aluControl;
    logic [1:0] immSrc;
    logic       illegalOp;
  } outs_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         fetchStall;
    int         memStall;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opIn;
  logic [2:0] f3In;
  logic       f7In;
  logic       zeroIn;
  logic       memReady;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_op;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0] alu_control;
  outs_t      actual;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .op(opIn), .funct3(f3In), .funct7b5(f7In),
    .zero(zeroIn), .mem_ready(memReady), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_control(alu_control), .imm_src(imm_src), .illegal_op(illegal_op)
  );

  assign actual = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                   alu_src_a, alu_src_b, result_src, alu_control, imm_src, illegal_op};

  // Reference: immediate format of each instruction class.
  function automatic logic [1:0] immRef(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // Reference: ALU function for an R/I-type execute step.
  function automatic logic [2:0] execRef(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o == RT && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic outs_t quiet(input logic [6:0] o);
    outs_t r;
    r = '0;
    r.immSrc = immRef(o);
    return r;
  endfunction

  function automatic outs_t fetchRef(input logic [6:0] o, input logic done);
    outs_t r;
    r = quiet(o);
    r.memReq = 1'b1;
    r.aluSrcB = 2'b10;
    r.resultSrc = 2'b10;
    r.irWrite = done;
    r.pcWrite = done;
    return r;
  endfunction

  function automatic outs_t srcRef(input logic [6:0] o, input logic [1:0] a, input logic [1:0] b);
    outs_t r;
    r = quiet(o);
    r.aluSrcA = a;
    r.aluSrcB = b;
    return r;
  endfunction

  task automatic checkOutput(input string name, input outs_t exp);
    checks++;
    if (actual !== exp) begin
      failures++;
      $display("[TB] FAIL %s t=%0t got=%h want=%h", name, $time, actual, exp);
    end
  endtask

  // Drive one cycle's inputs, check at the falling edge, then advance.
  task automatic applyStimulus(input logic rdy, input logic z, input outs_t exp, input string name);
    memReady = rdy;
    zeroIn = z;
    @(negedge clk);
    checkOutput(name, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic runInstr(input vec_t v);
    outs_t e;
    opIn = v.op;
    f3In = v.f3;
    f7In = v.f7;
    for (int k = 0; k < v.fetchStall; k++)
      applyStimulus(1'b0, 1'($urandom), fetchRef(v.op, 1'b0), {v.name, ".fetchWait"});
    applyStimulus(1'b1, 1'($urandom), fetchRef(v.op, 1'b1), {v.name, ".fetch"});
    applyStimulus(1'($urandom), 1'($urandom), srcRef(v.op, 2'b01, 2'b01), {v.name, ".decode"});
    if (v.op == LW || v.op == SW) begin
      applyStimulus(1'($urandom), 1'($urandom), srcRef(v.op, 2'b10, 2'b01), {v.name, ".memadr"});
      e = quiet(v.op);
      e.memReq = 1'b1;
      e.adrSrc = 1'b1;
      e.memWrite = (v.op == SW);
      for (int k = 0; k < v.memStall; k++)
        applyStimulus(1'b0, 1'($urandom), e, {v.name, ".memWait"});
      applyStimulus(1'b1, 1'($urandom), e, {v.name, ".mem"});
      if (v.op == LW) begin
        e = quiet(v.op);
        e.resultSrc = 2'b01;
        e.regWrite = 1'b1;
        applyStimulus(1'($urandom), 1'($urandom), e, {v.name, ".memwb"});
      end
    end else if (v.op == BQ) begin
      e = srcRef(v.op, 2'b10, 2'b00);
      e.aluControl = 3'b001;
      e.pcWrite = v.z;
      applyStimulus(1'($urandom), v.z, e, {v.name, ".beq"});
    end else begin
      if (v.op == JL) begin
        e = srcRef(v.op, 2'b01, 2'b10);
        e.pcWrite = 1'b1;
      end else begin
        e = srcRef(v.op, 2'b10, (v.op == IT) ? 2'b01 : 2'b00);
        e.aluControl = execRef(v.op, v.f3, v.f7);
      end
      applyStimulus(1'($urandom), 1'($urandom), e, {v.name, ".exec"});
      e = quiet(v.op);
      e.regWrite = 1'b1;
      applyStimulus(1'($urandom), 1'($urandom), e, {v.name, ".aluwb"});
    end
  endtask

  initial begin
    vec_t  table_q[$];
    vec_t  v;
    outs_t e;
    logic [6:0] ops[6];
    bit    done;

    ops = '{LW, SW, RT, IT, BQ, JL};
    table_q.push_back('{LW, 3'b010, 1'b0, 1'b0, 0, 0, "lw"});
    table_q.push_back('{SW, 3'b010, 1'b0, 1'b0, 0, 3, "swStall3"});
    table_q.push_back('{BQ, 3'b000, 1'b0, 1'b1, 0, 0, "beqTaken"});
    table_q.push_back('{BQ, 3'b000, 1'b0, 1'b0, 0, 0, "beqNotTaken"});
    table_q.push_back('{RT, 3'b000, 1'b1, 1'b0, 0, 0, "rSub"});
    table_q.push_back('{IT, 3'b000, 1'b1, 1'b0, 0, 0, "addiF7"});
    table_q.push_back('{RT, 3'b010, 1'b0, 1'b0, 0, 0, "rSlt"});
    table_q.push_back('{RT, 3'b110, 1'b0, 1'b0, 0, 0, "rOr"});
    table_q.push_back('{IT, 3'b111, 1'b0, 1'b0, 0, 0, "andi"});
    table_q.push_back('{IT, 3'b100, 1'b1, 1'b0, 0, 0, "xoriAsAdd"});
    table_q.push_back('{JL, 3'b000, 1'b0, 1'b0, 0, 0, "jal"});
    table_q.push_back('{LW, 3'b010, 1'b0, 1'b0, 2, 2, "lwStalls"});

    reset_n = 1'b0;
    opIn = IT;
    f3In = 3'b000;
    f7In = 1'b0;
    zeroIn = 1'b0;
    memReady = 1'b0;
    @(negedge clk);
    checkOutput("resetOutputs", fetchRef(IT, 1'b0));
    opIn = SW;
    #1;
    checkOutput("resetImmFollowsOp", fetchRef(SW, 1'b0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (table_q[i]) runInstr(table_q[i]);

    for (int n = 0; n < 150; n++) begin
      v.op = ops[$urandom_range(0, 5)];
      v.f3 = 3'($urandom);
      v.f7 = 1'($urandom);
      v.z = 1'($urandom);
      v.fetchStall = $urandom_range(0, 2);
      v.memStall = $urandom_range(0, 3);
      v.name = "rand";
      runInstr(v);
    end

    // Reset while a store is waiting on memory must drop the strobes at once.
    opIn = SW;
    f3In = 3'b010;
    applyStimulus(1'b1, 1'b0, fetchRef(SW, 1'b1), "rstSeq.fetch");
    applyStimulus(1'b0, 1'b0, srcRef(SW, 2'b01, 2'b01), "rstSeq.decode");
    applyStimulus(1'b0, 1'b0, srcRef(SW, 2'b10, 2'b01), "rstSeq.memadr");
    e = quiet(SW);
    e.memReq = 1'b1;
    e.memWrite = 1'b1;
    e.adrSrc = 1'b1;
    memReady = 1'b0;
    #1;
    checkOutput("rstSeq.memWriteHeld", e);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("rstSeq.asyncDrop", fetchRef(SW, 1'b0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, fetchRef(SW, 1'b1), "rstSeq.fetchAfter");
    applyStimulus(1'b1, 1'b0, srcRef(SW, 2'b01, 2'b01), "rstSeq.decodeAfter");

    // Finish that store so the illegal opcode starts from a clean fetch.
    applyStimulus(1'b1, 1'b0, srcRef(SW, 2'b10, 2'b01), "rstSeq.memadrAfter");
    applyStimulus(1'b1, 1'b0, e, "rstSeq.writeAfter");

    opIn = 7'b1111111;
    applyStimulus(1'b1, 1'b0, fetchRef(7'b1111111, 1'b1), "trap.fetch");
    applyStimulus(1'b1, 1'b0, srcRef(7'b1111111, 2'b01, 2'b01), "trap.decode");
    e = quiet(7'b1111111);
    e.illegalOp = 1'b1;
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b1, 1'($urandom), e, "trap.sticky");
    opIn = LW;
    e = quiet(LW);
    e.illegalOp = 1'b1;
    applyStimulus(1'b1, 1'b0, e, "trap.stickyNewOp");

    done = 1'b1;
    if (done) begin
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
